// File: rtl/wrr_pkt_write_arbiter.sv
// Purpose: packet-granular arbiter merging NUM_PORTS ingress streams into one SRAM write stream (strict priority or WRR).
// Latency: grant registered in IDLE, XFER next cycle; each accepted beat appears on the output register 1 cycle later.
// Backpressure: out_ready low with a beat held stalls the pop strobe to the granted port; nothing is dropped or repeated.
module wrr_pkt_write_arbiter #(
   parameter int NUM_PORTS     = 16,
   parameter int DATA_WIDTH    = 256,
   parameter int WEIGHT_WIDTH  = 4,
   parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              sp0_wrr1,
   input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight_p,
   input  logic [NUM_PORTS-1:0]              ready,
   input  logic [NUM_PORTS-1:0]              sop,
   input  logic [NUM_PORTS-1:0]              eop,
   input  logic [NUM_PORTS-1:0]              vld,
   input  logic [DATA_WIDTH*NUM_PORTS-1:0]   data_in_p,
   input  logic                              out_ready,
   output logic [NUM_PORTS-1:0]              next_data,
   output logic                              busy,
   output logic [DATA_WIDTH-1:0]             selected_data_out,
   output logic                              out_vld,
   output logic                              out_sop,
   output logic                              out_eop,
   output logic [PORT_ID_WIDTH-1:0]          out_port,
   output logic                              err_sop
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RELOAD = 2'd1,
      XFER   = 2'd2
   } state_t;

   // Per-beat side information carried alongside the output data register.
   typedef struct packed {
      logic                     sop;
      logic                     eop;
      logic [PORT_ID_WIDTH-1:0] port;
   } meta_t;

   state_t                   state_q, state_d;
   logic [PORT_ID_WIDTH-1:0] gnt_q, gnt_d;
   logic [PORT_ID_WIDTH-1:0] rr_q, rr_d;
   logic [WEIGHT_WIDTH-1:0]  credit_q [NUM_PORTS];
   logic [WEIGHT_WIDTH-1:0]  credit_d [NUM_PORTS];
   logic                     first_q, first_d;
   logic                     found;
   logic [PORT_ID_WIDTH-1:0] pick;
   logic [NUM_PORTS-1:0]     pop;
   logic                     xfer;
   meta_t                    meta_q;

   // Scan position k steps after base, wrapping at NUM_PORTS.
   function automatic int wrap_idx(input int base, input int k);
      int s;
      s = base + k;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      return s;
   endfunction

   // Weight of port i as seen by a reload; a zero weight still earns one packet per round.
   function automatic logic [WEIGHT_WIDTH-1:0] reload_val(input int i);
      logic [WEIGHT_WIDTH-1:0] w;
      w = weight_p[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      return (w == '0) ? WEIGHT_WIDTH'(1) : w;
   endfunction

   assign xfer = pop[gnt_q] & vld[gnt_q];

   // State register: arbitration state, lock, RR pointer and WRR credits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         rr_q    <= '0;
         first_q <= 1'b0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            credit_q[i] <= weight_p[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         end
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_q     <= rr_d;
         first_q  <= first_d;
         credit_q <= credit_d;
      end
   end

   // Next-state: grant selection in IDLE, credit reload, and release at eop.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      rr_d     = rr_q;
      first_d  = first_q;
      credit_d = credit_q;
      found    = 1'b0;
      pick     = '0;
      case (state_q)
         IDLE: begin
            if (ready != '0) begin
               if (!sp0_wrr1) begin
                  // Descending overwrite leaves the lowest ready index as winner.
                  for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                     if (ready[i]) gnt_d = PORT_ID_WIDTH'(i);
                  end
                  state_d = XFER;
                  first_d = 1'b1;
               end else begin
                  for (int k = 0; k < NUM_PORTS; k++) begin
                     if (!found && ready[wrap_idx(int'(rr_q), k)] &&
                         (credit_q[wrap_idx(int'(rr_q), k)] != '0)) begin
                        found = 1'b1;
                        pick  = PORT_ID_WIDTH'(wrap_idx(int'(rr_q), k));
                     end
                  end
                  if (found) begin
                     gnt_d           = pick;
                     credit_d[pick]  = credit_q[pick] - WEIGHT_WIDTH'(1);
                     state_d         = XFER;
                     first_d         = 1'b1;
                  end else begin
                     state_d = RELOAD;
                  end
               end
            end
         end
         RELOAD: begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               credit_d[i] = reload_val(i);
            end
            state_d = IDLE;
         end
         XFER: begin
            if (xfer) begin
               first_d = 1'b0;
               if (eop[gnt_q]) begin
                  state_d = IDLE;
                  rr_d    = (gnt_q == PORT_ID_WIDTH'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs from state: pop strobe to the locked port whenever the output register can take a beat.
   always_comb begin
      pop  = '0;
      busy = 1'b0;
      if (!rst && (state_q == XFER)) begin
         busy       = 1'b1;
         pop[gnt_q] = !out_vld || out_ready;
      end
   end

   assign next_data = pop;

   // Registered output stage and sop protocol check on the first beat of each grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         selected_data_out <= '0;
         meta_q            <= '0;
         out_vld           <= 1'b0;
         err_sop           <= 1'b0;
      end else begin
         err_sop <= xfer && first_q && !sop[gnt_q];
         if (xfer) begin
            selected_data_out <= data_in_p[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
            meta_q.sop        <= sop[gnt_q];
            meta_q.eop        <= eop[gnt_q];
            meta_q.port       <= gnt_q;
            out_vld           <= 1'b1;
         end else if (out_ready) begin
            out_vld <= 1'b0;
         end
      end
   end

   assign out_sop  = meta_q.sop;
   assign out_eop  = meta_q.eop;
   assign out_port = meta_q.port;

endmodule

// File: tb/tb_wrr_pkt_write_arbiter.sv
// Purpose: directed bench for wrr_pkt_write_arbiter with behavioural port sources and an output scoreboard.
// Latency: inputs change 1 time unit after posedge; DUT state is sampled on the falling edge.
// Backpressure: out_ready is driven directly by the stimulus sequence.
module tb_wrr_pkt_write_arbiter;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int WW = 4;
   localparam int PW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            sp0_wrr1;
   logic [N*WW-1:0] weight_p;
   logic [N-1:0]    ready, sop, eop, vld;
   logic [DW*N-1:0] data_in_p;
   logic            out_ready;
   logic [N-1:0]    next_data;
   logic            busy;
   logic [DW-1:0]   selected_data_out;
   logic            out_vld, out_sop, out_eop, err_sop;
   logic [PW-1:0]   out_port;

   wrr_pkt_write_arbiter #(
      .NUM_PORTS(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PORT_ID_WIDTH(PW)
   ) dut (
      .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .weight_p(weight_p),
      .ready(ready), .sop(sop), .eop(eop), .vld(vld), .data_in_p(data_in_p),
      .out_ready(out_ready), .next_data(next_data), .busy(busy),
      .selected_data_out(selected_data_out), .out_vld(out_vld),
      .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port), .err_sop(err_sop)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Source model state per port.
   int len [N];
   int bidx[N];
   int pcnt[N];
   int left[N];
   bit nosop[N];

   // Scoreboard of beats accepted downstream.
   int            q_port[$];
   bit            q_sop[$];
   bit            q_eop[$];
   logic [DW-1:0] q_dat[$];
   int            q_cyc[$];
   int            cyc = 0;
   int            err_cnt, err_cyc, busy_cnt;
   logic [N-1:0]  s_nd;
   logic          s_ov;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mkdat(input int p, input int pk, input int b);
      return DW'(p*4096 + pk*16 + b);
   endfunction

   task automatic drive();
      for (int p = 0; p < N; p++) begin
         ready[p] = (left[p] > 0);
         vld[p]   = (left[p] > 0);
         sop[p]   = (bidx[p] == 0) && !nosop[p];
         eop[p]   = (bidx[p] == len[p] - 1);
         data_in_p[p*DW +: DW] = mkdat(p, pcnt[p], bidx[p]);
      end
   endtask

   task automatic init_src();
      for (int p = 0; p < N; p++) begin
         len[p] = 1; bidx[p] = 0; pcnt[p] = 0; left[p] = 0; nosop[p] = 1'b0;
      end
   endtask

   task automatic clear_q();
      q_port.delete(); q_sop.delete(); q_eop.delete(); q_dat.delete(); q_cyc.delete();
      err_cnt = 0; err_cyc = -1; busy_cnt = 0;
   endtask

   task automatic cycle();
      logic [N-1:0] pop;
      @(negedge clk);
      pop  = next_data & vld;
      s_nd = next_data;
      s_ov = out_vld;
      if (busy) busy_cnt++;
      if (err_sop) begin err_cnt++; err_cyc = cyc; end
      if (out_vld && out_ready) begin
         q_port.push_back(int'(out_port));
         q_sop.push_back(out_sop);
         q_eop.push_back(out_eop);
         q_dat.push_back(selected_data_out);
         q_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < N; p++) begin
         if (pop[p]) begin
            if (bidx[p] == len[p] - 1) begin
               bidx[p] = 0; pcnt[p]++; left[p]--;
            end else begin
               bidx[p]++;
            end
         end
      end
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      init_src();
      drive();
      repeat (2) cycle();
      rst = 1'b0;
      clear_q();
   endtask

   task automatic run_beats(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (q_port.size() < n && k < budget) begin
         cycle();
         k++;
      end
      chk({tag, "_nbeats"}, 64'(q_port.size()), 64'(n));
   endtask

   task automatic chk_ports(input string tag, input int exp_p[$]);
      for (int i = 0; i < exp_p.size(); i++) begin
         if (i < q_port.size()) chk($sformatf("%s_port%0d", tag, i), 64'(q_port[i]), 64'(exp_p[i]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_p[$];
      int k;

      // Reset state
      rst = 1'b1; sp0_wrr1 = 1'b0; out_ready = 1'b1; weight_p = '0;
      init_src(); drive();
      repeat (3) cycle();
      chk("rst_out_vld",  64'(out_vld), 64'(0));
      chk("rst_busy",     64'(busy), 64'(0));
      chk("rst_next",     64'(next_data), 64'(0));
      chk("rst_port",     64'(out_port), 64'(0));
      chk("rst_data",     64'(selected_data_out), 64'(0));
      chk("rst_err",      64'(err_sop), 64'(0));
      chk("rst_sop_eop",  64'({out_sop, out_eop}), 64'(0));
      rst = 1'b0;
      clear_q();

      // Strict priority: ports 1 and 3, three beats each
      left[1] = 1; left[3] = 1; len[1] = 3; len[3] = 3; drive();
      run_beats(6, 40, "sp");
      for (int i = 0; i < 6 && i < q_port.size(); i++) begin
         chk($sformatf("sp_port%0d", i), 64'(q_port[i]), 64'((i < 3) ? 1 : 3));
         chk($sformatf("sp_sop%0d", i),  64'(q_sop[i]),  64'((i % 3) == 0));
         chk($sformatf("sp_eop%0d", i),  64'(q_eop[i]),  64'((i % 3) == 2));
         chk($sformatf("sp_dat%0d", i),  64'(q_dat[i]),  64'(mkdat((i < 3) ? 1 : 3, 0, i % 3)));
      end
      if (q_cyc.size() >= 4) begin
         chk("sp_tput", 64'(q_cyc[2] - q_cyc[0]), 64'(2));
         chk("sp_gap",  64'(q_cyc[3] - q_cyc[2]), 64'(2));
      end
      chk("sp_busy_cycles", 64'(busy_cnt), 64'(6));
      chk("sp_no_err", 64'(err_cnt), 64'(0));

      // WRR: p0 weight 3, p1 weight 1, single-beat packets
      sp0_wrr1 = 1'b1;
      weight_p = {4'd0, 4'd0, 4'd1, 4'd3};
      do_reset();
      left[0] = 100; left[1] = 100; drive();
      run_beats(8, 60, "wrr");
      exp_p = '{0, 1, 0, 0, 1, 0, 0, 0};
      chk_ports("wrr", exp_p);
      if (q_cyc.size() >= 6) begin
         chk("wrr_gap_norm",   64'(q_cyc[1] - q_cyc[0]), 64'(2));
         chk("wrr_gap_reload", 64'(q_cyc[4] - q_cyc[3]), 64'(4));
         chk("wrr_gap_after",  64'(q_cyc[5] - q_cyc[4]), 64'(2));
      end

      // Backpressure: three stall cycles while beat 1 is held
      sp0_wrr1 = 1'b0;
      do_reset();
      len[2] = 4; left[2] = 1; drive();
      repeat (3) cycle();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk($sformatf("bp_nd_stall%0d", i), 64'(s_nd[2]), 64'(0));
         chk($sformatf("bp_ov_stall%0d", i), 64'(s_ov), 64'(1));
      end
      out_ready = 1'b1;
      run_beats(4, 20, "bp");
      repeat (4) cycle();
      chk("bp_no_dup", 64'(q_port.size()), 64'(4));
      for (int i = 0; i < 4 && i < q_dat.size(); i++) begin
         chk($sformatf("bp_dat%0d", i), 64'(q_dat[i]), 64'(mkdat(2, 0, i)));
      end
      if (q_cyc.size() >= 2) chk("bp_stall_len", 64'(q_cyc[1] - q_cyc[0]), 64'(4));
      if (q_eop.size() >= 4) chk("bp_eop", 64'({q_sop[0], q_eop[3]}), 64'(2'b11));

      // Lock: port 0 and a mode flip arrive during port 2's packet
      sp0_wrr1 = 1'b0;
      do_reset();
      len[2] = 4; left[2] = 1; drive();
      repeat (2) cycle();
      left[0] = 1; len[0] = 1; sp0_wrr1 = 1'b1; drive();
      cycle();
      sp0_wrr1 = 1'b0;
      cycle();
      run_beats(5, 30, "lock");
      exp_p = '{2, 2, 2, 2, 0};
      chk_ports("lock", exp_p);
      if (q_dat.size() >= 5) begin
         chk("lock_p0_dat", 64'(q_dat[4]), 64'(mkdat(0, 0, 0)));
         chk("lock_p0_se",  64'({q_sop[4], q_eop[4]}), 64'(2'b11));
      end

      // Reset mid-packet after beat 1; RR pointer must restart at 0
      sp0_wrr1 = 1'b1;
      weight_p = 16'h1111;
      do_reset();
      len[2] = 4; left[2] = 2; drive();
      run_beats(4, 30, "rstm_pkt1");
      k = 0;
      while (bidx[2] != 2 && k < 20) begin cycle(); k++; end
      chk("rstm_reach_beat1", 64'(bidx[2]), 64'(2));
      chk("rstm_busy_before", 64'(busy), 64'(1));
      rst = 1'b1;
      cycle();
      chk("rstm_nd_in_rst", 64'(s_nd), 64'(0));
      chk("rstm_out_vld", 64'(out_vld), 64'(0));
      chk("rstm_busy",    64'(busy), 64'(0));
      chk("rstm_next",    64'(next_data), 64'(0));
      rst = 1'b0;
      init_src();
      left[1] = 1; left[3] = 1;
      clear_q();
      drive();
      run_beats(2, 30, "rstm");
      exp_p = '{1, 3};
      chk_ports("rstm", exp_p);

      // Missing sop on the first beat of a grant
      sp0_wrr1 = 1'b0;
      do_reset();
      len[0] = 2; left[0] = 1; nosop[0] = 1'b1; drive();
      run_beats(2, 20, "esop");
      repeat (3) cycle();
      chk("esop_pulse_cnt", 64'(err_cnt), 64'(1));
      if (q_cyc.size() >= 1) begin
         chk("esop_pulse_cyc", 64'(err_cyc), 64'(q_cyc[0]));
         chk("esop_out_sop",   64'(q_sop[0]), 64'(0));
         chk("esop_dat",       64'(q_dat[0]), 64'(mkdat(0, 0, 0)));
         chk("esop_port",      64'(q_port[0]), 64'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
